switch_debouncer: RTL and testbench

Front-end conditioning stage for the board switch inputs. It synchronises the raw `switch` bus into `clk`, rejects bounces and glitches with a per-bit stability counter, and emits a clean switch code plus per-bit edge pulses. Its outputs drive the `switch` and `enable` inputs of the LED-pattern block directly downstream.

---
 rtl/switch_debouncer_pkg.sv | 12 +
 rtl/switch_debouncer_debounce_bit.sv | 74 +++++++
 rtl/switch_debouncer.sv | 90 +++++++++
 tb/tb_switch_debouncer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/switch_debouncer_pkg.sv
// Shared types and default sizing for the switch debouncer.
package switch_debouncer_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned SW_WIDTH         = 3;
  localparam int unsigned SW_STABLE_CYCLES = 4;

endpackage

// File: rtl/switch_debouncer_debounce_bit.sv
// One switch bit: 2-flop synchroniser, stability counter, clean level and edge pulses.
module debounce_bit
  import switch_debouncer_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = SW_STABLE_CYCLES,
  parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic run,
  input  logic load,
  input  logic sw,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic rise_next,
  output logic fall_next
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clean_q, clean_d;
  logic             rise_q, fall_q;

  always_comb begin
    cnt_d     = cnt_q;
    clean_d   = clean_q;
    rise_next = 1'b0;
    fall_next = 1'b0;
    if (load) begin
      // Initial capture is silent: no pulses.
      clean_d = sync2_q;
    end else if (run) begin
      if (sync2_q == clean_q) begin
        cnt_d = '0;
      end else if (enable) begin
        if (cnt_q == CntLast) begin
          clean_d   = sync2_q;
          cnt_d     = '0;
          rise_next = sync2_q;
          fall_next = ~sync2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_next;
      fall_q  <= fall_next;
    end
  end

  assign clean = clean_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/switch_debouncer.sv
// Switch debouncer top: INIT/RUN sequencing, initial-capture counter, per-bit debounce lanes.
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int unsigned WIDTH         = SW_WIDTH,
  parameter int unsigned STABLE_CYCLES = SW_STABLE_CYCLES,
  parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] switch,
  output logic [WIDTH-1:0] switch_clean,
  output logic             switch_valid,
  output logic             changed,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  // Must hold STABLE_CYCLES+1, one more than the per-bit counters.
  localparam int unsigned INIT_W = $clog2(STABLE_CYCLES + 2);
  localparam logic [INIT_W-1:0] InitLast = INIT_W'(STABLE_CYCLES + 1);

  state_t            state_q, state_d;
  logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
  logic              valid_q;
  logic              changed_q;
  logic              load;
  logic              run;
  logic [WIDTH-1:0]  rise_next, fall_next;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    load       = 1'b0;
    unique case (state_q)
      INIT: begin
        if (enable) begin
          if (init_cnt_q == InitLast) begin
            load    = 1'b1;
            state_d = RUN;
          end else begin
            init_cnt_d = init_cnt_q + 1'b1;
          end
        end
      end
      RUN: state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  assign run = (state_q == RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      valid_q    <= 1'b0;
      changed_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      valid_q    <= valid_q | load;
      changed_q  <= |(rise_next | fall_next);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .CNT_W        (CNT_W)
    ) u_bit (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .run      (run),
      .load     (load),
      .sw       (switch[i]),
      .clean    (switch_clean[i]),
      .rise     (rise[i]),
      .fall     (fall[i]),
      .rise_next(rise_next[i]),
      .fall_next(fall_next[i])
    );
  end

  assign switch_valid = valid_q;
  assign changed      = changed_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer (WIDTH=3, STABLE_CYCLES=4).
module tb_switch_debouncer;

  localparam int LAT = 6;  // raw step to clean update, enable held high

  typedef struct packed {
    int          cyc;
    logic [10:0] vec;  // {clean, valid, rise, fall, changed}
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b1;
  logic [2:0] switch = 3'b101;
  logic [2:0] switch_clean, rise, fall;
  logic       switch_valid, changed;

  switch_debouncer #(
    .WIDTH        (3),
    .STABLE_CYCLES(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .switch      (switch),
    .switch_clean(switch_clean),
    .switch_valid(switch_valid),
    .changed     (changed),
    .rise        (rise),
    .fall        (fall)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t ev_q[$];
  exp_t snap_q[$];
  int   checks = 0;
  int   errors = 0;
  logic done = 1'b0;
  logic valid_prev = 1'b0;

  function automatic logic [10:0] mk(input logic [2:0] cl, input logic v, input logic [2:0] r,
                                     input logic [2:0] f, input logic ch);
    return {cl, v, r, f, ch};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int lat, input logic [2:0] cl, input logic [2:0] r,
                           input logic [2:0] f, input logic ch);
    exp_t e;
    e.cyc = cyc + lat;
    e.vec = mk(cl, 1'b1, r, f, ch);
    ev_q.push_back(e);
  endtask

  task automatic snap(input logic [10:0] v);
    exp_t e;
    e.cyc = cyc;
    e.vec = v;
    snap_q.push_back(e);
  endtask

  // Monitor: an output event is a pulse or the rising edge of switch_valid.
  always @(negedge clk) begin
    exp_t        e;
    logic        ev;
    logic [10:0] act;
    act = {switch_clean, switch_valid, rise, fall, changed};
    while (ev_q.size() > 0 && (done || ev_q[0].cyc < cyc)) begin
      e = ev_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_event: no event observed, required %b at cycle %0d", e.vec, e.cyc);
    end
    while (snap_q.size() > 0 && (done || snap_q[0].cyc < cyc)) begin
      e = snap_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_snapshot: not sampled, required %b at cycle %0d", e.vec, e.cyc);
    end
    if (snap_q.size() > 0 && snap_q[0].cyc == cyc) begin
      e = snap_q.pop_front();
      checks++;
      if (act !== e.vec) begin
        errors++;
        $display("FAIL snapshot cycle %0d: got %b, required %b", cyc, act, e.vec);
      end
    end
    ev = changed || (rise != 3'b000) || (fall != 3'b000) || (switch_valid && !valid_prev);
    if (ev) begin
      checks++;
      if (ev_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cycle %0d: got %b, required no event", cyc, act);
      end else begin
        e = ev_q.pop_front();
        if (e.cyc != cyc) begin
          errors++;
          $display("FAIL event_cycle: got cycle %0d, required cycle %0d", cyc, e.cyc);
        end
        checks++;
        if (act !== e.vec) begin
          errors++;
          $display("FAIL event_value cycle %0d: got %b, required %b", cyc, act, e.vec);
        end
      end
    end
    valid_prev = switch_valid;
  end

  initial begin
    // Reset and INIT: 101 captured after the 6th edge, silently.
    step(3);
    rst = 1'b1;
    snap(mk(3'b000, 1'b0, 3'b000, 3'b000, 1'b0));
    expect_ev(LAT, 3'b101, 3'b000, 3'b000, 1'b0);
    step(5);
    snap(mk(3'b000, 1'b0, 3'b000, 3'b000, 1'b0));
    step(3);

    // Clean updates: 101 -> 000 -> 010.
    switch = 3'b000;
    expect_ev(LAT, 3'b000, 3'b000, 3'b101, 1'b1);
    step(8);
    switch = 3'b010;
    expect_ev(LAT, 3'b010, 3'b010, 3'b000, 1'b1);
    step(8);

    // Glitch of 3 cycles on bit 0 is the longest one that must be rejected.
    switch = 3'b011;
    step(3);
    switch = 3'b010;
    step(10);
    snap(mk(3'b010, 1'b1, 3'b000, 3'b000, 1'b0));

    // Set bit 2, then freeze its falling transition after two counts.
    switch = 3'b110;
    expect_ev(LAT, 3'b110, 3'b100, 3'b000, 1'b1);
    step(8);
    switch = 3'b010;
    expect_ev(LAT + 5, 3'b010, 3'b000, 3'b100, 1'b1);
    step(4);
    enable = 1'b0;
    step(3);
    snap(mk(3'b110, 1'b1, 3'b000, 3'b000, 1'b0));
    step(2);
    enable = 1'b1;
    step(6);

    // Simultaneous rise and fall from 011 to 100.
    switch = 3'b011;
    expect_ev(LAT, 3'b011, 3'b001, 3'b000, 1'b1);
    step(8);
    switch = 3'b100;
    expect_ev(LAT, 3'b100, 3'b100, 3'b011, 1'b1);
    step(8);

    // Reset two cycles into a pending change, then silent re-capture.
    switch = 3'b111;
    step(2);
    rst = 1'b0;
    snap(mk(3'b000, 1'b0, 3'b000, 3'b000, 1'b0));
    step(3);
    rst = 1'b1;
    snap(mk(3'b000, 1'b0, 3'b000, 3'b000, 1'b0));
    expect_ev(LAT, 3'b111, 3'b000, 3'b000, 1'b0);
    step(10);

    done = 1'b1;
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
